// File: rtl/imem_pkg.sv
// Shared constants, response type and width helper for the pipelined instruction memory.
// Pure definitions: no latency, no flow control.
// fetch_resp_t is the default-width response; the top builds its own copy sized to DATA_WIDTH.
package imem_pkg;

    localparam int IMEM_WORD_OFFSET = 2;
    localparam int IMEM_DATA_WIDTH  = 32;

    typedef struct packed {
        logic [IMEM_DATA_WIDTH-1:0] data;
        logic                       fault;
        logic                       perr;
    } fetch_resp_t;

    // Never returns less than 1 so single-entry structures still get a usable index width.
    function automatic int imem_clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Response buffer between the read pipeline and the fetch stage, with synchronous clear.
// Latency: a push becomes visible at the head one cycle later; no empty bypass.
// Backpressure: none internally; the caller's credit scheme guarantees it is never overfilled.
module imem_resp_fifo
    import imem_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_resp_t
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  T                               push_data,
    input  logic                           pop,
    output T                               head,
    output logic [imem_clog2(DEPTH+1)-1:0] count
);

    localparam int PW = imem_clog2(DEPTH);
    localparam int CW = imem_clog2(DEPTH + 1);

    T              entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) entries[wr_ptr] <= push_data;
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Instruction memory with program-load port, READ_LATENCY-stage read pipeline and buffered responses.
// Latency: accept at edge N -> resp_valid after edge N+READ_LATENCY; flush drops everything in flight.
// Backpressure: req_ready is credit-gated on outstanding responses; IMEM_PARITY_EN adds stored even parity.
module instruction_memory_pipelined
    import imem_pkg::*;
#(
    parameter int MEM_DEPTH    = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_fault,
    input  logic                  flush,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  resp_perr
);

    localparam int IW = imem_clog2(MEM_DEPTH);
    localparam int CW = imem_clog2(RESP_DEPTH + 1);
`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  fault;
        logic                  perr;
    } resp_t;

    logic [MW-1:0]           mem [MEM_DEPTH];
    logic [MW-1:0]           mem_q;
    logic [IW-1:0]           req_idx;
    logic [IW-1:0]           prog_idx;
    logic                    req_fault;
    logic                    prog_in_range;
    logic                    accept;
    logic                    pop;
    resp_t                   rd_resp;
    resp_t                   fifo_head;
    logic [READ_LATENCY-1:0] stg_vld;
    resp_t                   stg_dat [READ_LATENCY];
    logic [CW-1:0]           credit_cnt;
    logic [CW-1:0]           fifo_count;
    logic                    unused_prog_lsb;

    assign req_idx  = req_addr[IW+IMEM_WORD_OFFSET-1:IMEM_WORD_OFFSET];
    assign prog_idx = prog_addr[IW+IMEM_WORD_OFFSET-1:IMEM_WORD_OFFSET];

    // Range is checked on the full address so high addresses never alias onto the array.
    assign req_fault     = (req_addr[IMEM_WORD_OFFSET-1:0] != '0) ||
                           (req_addr[ADDR_WIDTH-1:IW+IMEM_WORD_OFFSET] != '0);
    assign prog_in_range = (prog_addr[ADDR_WIDTH-1:IW+IMEM_WORD_OFFSET] == '0);
    assign unused_prog_lsb = ^prog_addr[IMEM_WORD_OFFSET-1:0];

    assign req_ready = !reset && !flush && (credit_cnt < CW'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
`ifdef IMEM_PARITY_EN
            mem[prog_idx] <= {^prog_data, prog_data};
`else
            mem[prog_idx] <= prog_data;
`endif
        end
    end

    assign mem_q = mem[req_idx];

    always_comb begin
        rd_resp       = '0;
        rd_resp.fault = req_fault;
        if (!req_fault) begin
            rd_resp.data = mem_q[DATA_WIDTH-1:0];
`ifdef IMEM_PARITY_EN
            rd_resp.perr = ^mem_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_vld <= '0;
        end else if (flush) begin
            stg_vld <= '0;
        end else begin
            stg_vld[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) stg_dat[0] <= rd_resp;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stg_dat[i] <= stg_dat[i-1];
        end
    end

    // Credits cover pipeline plus FIFO, so a freshly accepted read always has a slot waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_cnt <= '0;
        end else if (flush) begin
            credit_cnt <= '0;
        end else if (accept && !pop) begin
            credit_cnt <= credit_cnt + CW'(1);
        end else if (pop && !accept) begin
            credit_cnt <= credit_cnt - CW'(1);
        end
    end

    imem_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (resp_t)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (stg_vld[READ_LATENCY-1]),
        .push_data (stg_dat[READ_LATENCY-1]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign resp_valid = (fifo_count != '0);
    assign resp_data  = resp_valid ? fifo_head.data : '0;
    assign resp_fault = resp_valid && fifo_head.fault;
    assign resp_perr  = resp_valid && fifo_head.perr;

endmodule
